codec_des_pipe: RTL and testbench

CODEC_DES_PIPE -- requirements
Module: codec_des_pipe

---
 rtl/codec_des_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_codec_des_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_des_pipe.sv
// DES block engine: one 64-bit block in flight, ROUNDS_PER_CYCLE Feistel rounds per clock.
// Define CODEC_DES_CBC_EN to add CBC chaining (iv / iv_load ports and a chain register).
module codec_des_pipe #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
`ifdef CODEC_DES_CBC_EN
  input  logic [63:0] iv,
  input  logic        iv_load,
`endif
  output logic        busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] LAST = 4'(16 - ROUNDS_PER_CYCLE);

  // Tables use FIPS 46-3 1-based bit numbers; FIPS bit n of a W-bit vector is vector bit W-n.
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                               8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                              16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                              24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                               2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // S-box b occupies entries 64*b .. 64*b+63, row-major (row = outer bits, column = inner bits).
  localparam int SBOX [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,  0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,  15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,  3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,  13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,  1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,  13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,  3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,  14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,  11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,  10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,  4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,  13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,  6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,  1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,  2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  function automatic logic [63:0] perm_ip(input logic [63:0] d);
    logic [63:0] o;
    for (int j = 0; j < 64; j++) o[63-j] = d[64-IP_T[j]];
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] d);
    logic [63:0] o;
    for (int j = 0; j < 64; j++) o[63-j] = d[64-FP_T[j]];
    return o;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] d);
    logic [55:0] o;
    for (int j = 0; j < 56; j++) o[55-j] = d[64-PC1_T[j]];
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] d);
    logic [47:0] o;
    for (int j = 0; j < 48; j++) o[47-j] = d[56-PC2_T[j]];
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    return (n == 1) ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-E_T[j]];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      s[31-4*i -: 4] = 4'(SBOX[64*i + 16*int'({b[5], b[0]}) + int'(b[4:1])]);
    end
    for (int j = 0; j < 32; j++) o[31-j] = s[32-P_T[j]];
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q;
  logic [3:0]  rnd_q;
  logic [63:0] lr_q, lr_d;
  logic [63:0] key_q;
  logic        dec_q;
  logic        out_valid_q;
  logic [63:0] out_data_q, res_d;
  logic [63:0] blk_in;
  logic [47:0] subkey [16];
`ifdef CODEC_DES_CBC_EN
  logic [63:0] chain_q, chain_in, blk_q;
`endif

  always_comb begin : key_sched
    logic [55:0] cd;
    cd = perm_pc1(key_q);
    for (int i = 0; i < 16; i++) begin
      cd = {rotl28(cd[55:28], SHIFT_T[i]), rotl28(cd[27:0], SHIFT_T[i])};
      subkey[i] = perm_pc2(cd);
    end
  end

  // Decrypt walks the schedule backwards: round r uses K[15-r], i.e. index ~r.
  always_comb begin : rounds
    logic [31:0] l, r, t;
    logic [3:0]  idx;
    l = lr_q[63:32];
    r = lr_q[31:0];
    t = '0;
    idx = '0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      idx = rnd_q + 4'(i);
      t = r;
      r = l ^ feistel(r, dec_q ? subkey[~idx] : subkey[idx]);
      l = t;
    end
    lr_d = {l, r};
    res_d = perm_fp({r, l});
`ifdef CODEC_DES_CBC_EN
    if (dec_q) res_d = res_d ^ chain_q;
`endif
  end

  always_comb begin
    blk_in = in_data;
`ifdef CODEC_DES_CBC_EN
    chain_in = iv_load ? iv : chain_q;
    if (!in_decrypt) blk_in = in_data ^ chain_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      lr_q        <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef CODEC_DES_CBC_EN
      chain_q     <= '0;
      blk_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef CODEC_DES_CBC_EN
          if (iv_load) chain_q <= iv;
`endif
          if (in_valid) begin
            state_q <= RUN;
            rnd_q   <= '0;
            lr_q    <= perm_ip(blk_in);
            key_q   <= in_key;
            dec_q   <= in_decrypt;
`ifdef CODEC_DES_CBC_EN
            blk_q   <= in_data;
`endif
          end
        end
        RUN: begin
          lr_q  <= lr_d;
          rnd_q <= rnd_q + STEP;
          if (rnd_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
`ifdef CODEC_DES_CBC_EN
            chain_q     <= dec_q ? blk_q : out_data_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_codec_des_pipe.sv
// Directed bench for codec_des_pipe: unit 0 runs at 1 round/clock, units 1-3 at 2, 4 and 16.
module tb_codec_des_pipe;

  localparam int RPC_T [4] = '{1, 2, 4, 16};
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid, in_ready, out_valid, busy;
  logic [63:0] in_data, in_key;
  logic        in_decrypt;
  logic        out_ready;
  logic [63:0] out_data [4];
`ifdef CODEC_DES_CBC_EN
  logic [63:0] iv;
  logic        iv_load;
  bit          zero_chain;
`endif

  int checks, errors;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    codec_des_pipe #(.ROUNDS_PER_CYCLE(RPC_T[g])) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_data(out_data[g]),
`ifdef CODEC_DES_CBC_EN
      .iv(iv), .iv_load(iv_load),
`endif
      .busy(busy[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with unit u idle; returns at the negedge where out_valid is first seen,
  // plus one more negedge when out_ready is high so the handshake has completed.
  task automatic do_block(input int u, input logic [63:0] key, input logic [63:0] data,
                          input logic dec, input logic [63:0] exp, input int exp_lat,
                          input string tag, output logic [63:0] got);
    int lat;
    in_key = key;
    in_data = data;
    in_decrypt = dec;
`ifdef CODEC_DES_CBC_EN
    iv = '0;
    iv_load = zero_chain;
`endif
    chk({tag, " in_ready"}, 64'(in_ready[u]), 64'd1);
    in_valid[u] = 1'b1;
    @(negedge clk);
    in_valid[u] = 1'b0;
`ifdef CODEC_DES_CBC_EN
    iv_load = 1'b0;
`endif
    in_key = ~key;
    in_data = ~data;
    in_decrypt = ~dec;
    chk({tag, " busy"}, 64'(busy[u]), 64'd1);
    lat = 0;
    while (!out_valid[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    if (!$isunknown(exp)) chk({tag, " data"}, out_data[u], exp);
    got = out_data[u];
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    logic [63:0] got, c1, c2;
    int stall_bad, seen;
    int lat [4];
    logic [63:0] dat [4];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    in_data = '0;
    in_key = '0;
    in_decrypt = 1'b0;
`ifdef CODEC_DES_CBC_EN
    iv = '0;
    iv_load = 1'b0;
    zero_chain = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(out_valid[0]), 64'd0);
    chk("reset out_data", out_data[0], 64'd0);
    chk("reset busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 64'(in_ready[0]), 64'd1);

    do_block(0, K1, P1, 1'b0, C1, 16, "enc K1", got);
    do_block(0, K1, C1, 1'b1, P1, 16, "dec K1", got);
    do_block(0, K2, P2, 1'b0, 64'h0, 16, "enc K2", got);
    do_block(0, K2, 64'h0, 1'b1, P2, 16, "dec K2", got);
    do_block(0, 64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 16, "enc zero", got);
    do_block(0, '1, '1, 1'b0, 64'h7359B2163E4EDC58, 16, "enc ones", got);
    do_block(0, 64'h123556789ABDDEF0, P1, 1'b0, C1, 16, "parity ignored", got);
    do_block(0, P1, 64'h4E6F772069732074, 1'b0, 64'h3FA40E8A984D4815, 16, "enc now-is-t", got);

    // Output stall with an intruding in_valid pulse
    out_ready = 1'b0;
    do_block(0, K1, P1, 1'b0, C1, 16, "stall", got);
    stall_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        in_valid[0] = 1'b1;
        in_data = 64'hDEADBEEFCAFEF00D;
      end
      if (c == 6) in_valid[0] = 1'b0;
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || out_data[0] !== C1 || in_ready[0] !== 1'b0) stall_bad++;
    end
    chk("stall hold cycles bad", 64'(stall_bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall release out_valid", 64'(out_valid[0]), 64'd0);
    chk("stall release in_ready", 64'(in_ready[0]), 64'd1);
    do_block(0, K1, C1, 1'b1, P1, 16, "after stall", got);

    // Reset at round 7
    in_key = K2;
    in_data = P2;
    in_decrypt = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid-run busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-run rst out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid-run rst out_data", out_data[0], 64'd0);
    chk("mid-run rst busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) seen++;
    end
    chk("no result after reset", 64'(seen), 64'd0);

    // Reset while DONE, then accept on the first edge after release
    out_ready = 1'b0;
    do_block(0, K1, P1, 1'b0, C1, 16, "done pre-reset", got);
    rst_n = 1'b0;
    #1;
    chk("done rst out_valid", 64'(out_valid[0]), 64'd0);
    chk("done rst out_data", out_data[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_block(0, 64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 16, "first edge after reset", got);

    // All four round-per-cycle variants on the same block
    in_key = K1;
    in_data = P1;
    in_decrypt = 1'b0;
`ifdef CODEC_DES_CBC_EN
    iv = '0;
    iv_load = 1'b1;
`endif
    in_valid = 4'hF;
    @(negedge clk);
    in_valid = '0;
`ifdef CODEC_DES_CBC_EN
    iv_load = 1'b0;
`endif
    for (int u = 0; u < 4; u++) begin
      lat[u] = -1;
      dat[u] = '0;
    end
    for (int c = 0; c < 24; c++) begin
      for (int u = 0; u < 4; u++) begin
        if (out_valid[u] && lat[u] < 0) begin
          lat[u] = c;
          dat[u] = out_data[u];
        end
      end
      @(negedge clk);
    end
    chk("rpc1 latency", 64'(lat[0]), 64'd16);
    chk("rpc2 latency", 64'(lat[1]), 64'd8);
    chk("rpc4 latency", 64'(lat[2]), 64'd4);
    chk("rpc16 latency", 64'(lat[3]), 64'd1);
    chk("rpc1 data", dat[0], C1);
    chk("rpc2 data", dat[1], C1);
    chk("rpc4 data", dat[2], C1);
    chk("rpc16 data", dat[3], C1);
    do_block(3, K2, 64'h0, 1'b1, P2, 1, "rpc16 dec K2", got);

`ifdef CODEC_DES_CBC_EN
    zero_chain = 1'b1;
    do_block(0, K1, P1, 1'b0, C1, 16, "cbc enc 1", c1);
    zero_chain = 1'b0;
    do_block(0, K1, P1, 1'b0, 64'bx, 16, "cbc enc 2", c2);
    chk("cbc c2 differs from c1", 64'(c2 !== c1), 64'd1);
    zero_chain = 1'b1;
    do_block(0, K1, c1, 1'b1, P1, 16, "cbc dec 1", got);
    zero_chain = 1'b0;
    do_block(0, K1, c2, 1'b1, P1, 16, "cbc dec 2", got);
`else
    c1 = '0;
    c2 = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
